// File: rtl/gelato_inst_mem_responder.sv
// Instruction line-fill responder: one outstanding line request, fixed access latency,
// then a LINE_WORDS-beat burst under valid/ready. Optional macro GELATO_IMEM_CRITICAL_WORD_FIRST_EN.
module gelato_inst_mem_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 4096,
   parameter int LINE_WORDS = 8,
   parameter int LATENCY    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rdy,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [DATA_WIDTH-1:0]        resp_data,
   output logic                         resp_last,
   input  logic                         load_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]        load_data
);
   // state   | meaning
   // S_IDLE  | ready for a line request
   // S_WAIT  | counting down access latency
   // S_BURST | presenting line beats
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   localparam int MA_W  = $clog2(MEM_DEPTH);
   localparam int LW_W  = $clog2(LINE_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD  = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
   localparam logic [LW_W-1:0]  LAST_BEAT = LW_W'(LINE_WORDS - 1);
   localparam logic [MA_W-1:0]  LINE_MASK = ~MA_W'(LINE_WORDS - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LW_W-1:0]   beat_q, beat_d;
   logic [MA_W-1:0]   base_q, base_d;
   logic [MA_W-1:0]   req_word;
   logic [LW_W-1:0]   line_off;
   logic [MA_W-1:0]   rd_idx;
   logic              unused_addr;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // Word index modulo the array depth; upper and byte-lane address bits are dropped.
   assign req_word    = req_addr[MA_W+1:2];
   assign unused_addr = ^req_addr;

`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
   logic [LW_W-1:0] start_q, start_d;
   assign line_off = start_q + beat_q;
`else
   assign line_off = beat_q;
`endif

   assign rd_idx = base_q | MA_W'(line_off);

   always_ff @(posedge clk) begin
      if (load_we) mem_q[load_addr] <= load_data;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      base_d     = base_q;
`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
      start_d    = start_q;
`endif
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_data  = '0;
      case (state_q)
         S_IDLE: begin
            req_ready = rdy & rst_n;
            if (req_valid && req_ready) begin
               base_d = req_word & LINE_MASK;
               beat_d = '0;
`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
               start_d = req_word[LW_W-1:0];
`endif
               if (LATENCY > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = S_BURST;
               end
            end
         end
         S_WAIT: begin
            if (rdy) begin
               if (cnt_q == '0) state_d = S_BURST;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         S_BURST: begin
            resp_valid = rdy;
            if (resp_valid) begin
               resp_data = mem_q[rd_idx];
               resp_last = (beat_q == LAST_BEAT);
               if (resp_ready) begin
                  if (resp_last) begin
                     beat_d  = '0;
                     state_d = S_IDLE;
                  end else begin
                     beat_d = beat_q + LW_W'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         beat_q  <= '0;
         base_q  <= '0;
`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
         start_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
         start_q <= start_d;
`endif
      end
   end

endmodule

// File: tb/tb_gelato_inst_mem_responder.sv
// Directed bench for gelato_inst_mem_responder: default build plus a LATENCY=0, MEM_DEPTH=16 copy.
module tb_gelato_inst_mem_responder;
`ifdef GELATO_IMEM_CRITICAL_WORD_FIRST_EN
   localparam int START_14 = 5;
   localparam int START_44 = 1;
`else
   localparam int START_14 = 0;
   localparam int START_44 = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy, req_valid, req_ready, resp_valid, resp_ready, resp_last, load_we;
   logic [31:0] req_addr, resp_data, load_data;
   logic [11:0] load_addr;

   logic        rdy0, req_valid0, req_ready0, resp_valid0, resp_ready0, resp_last0, load_we0;
   logic [31:0] req_addr0, resp_data0, load_data0;
   logic [3:0]  load_addr0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gelato_inst_mem_responder u_dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
   );

   gelato_inst_mem_responder #(.MEM_DEPTH(16), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rdy(rdy0),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0), .resp_last(resp_last0),
      .load_we(load_we0), .load_addr(load_addr0), .load_data(load_data0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_req(input logic [31:0] a);
      int n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      #1;
      while (!req_ready && n < 20) begin
         tick();
         n++;
         #1;
      end
      check("req_ready_idle", req_ready, 1);
      tick();
      req_valid = 1'b0;
      #1;
      check("req_ready_busy", req_ready, 0);
      check("resp_valid_wait", resp_valid, 0);
   endtask

   // Counts cycles from the acceptance edge to the first valid beat.
   task automatic wait_first(input int exp_lat, input int fs, input int fl);
      int k = 0;
      while (k < 50) begin
         rdy = !(k >= fs && k < fs + fl);
         #1;
         if (!rdy) check("frz_wait_valid", resp_valid, 0);
         if (resp_valid) break;
         tick();
         k++;
      end
      rdy = 1'b1;
      check("first_beat_latency", k, exp_lat);
   endtask

   task automatic collect(input logic [31:0] base_val, input int start, input bit bp, input int frz_at);
      int beats = 0;
      int cyc = 0;
      while (beats < 8 && cyc < 60) begin
         resp_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         rdy = !(frz_at >= 0 && cyc >= frz_at && cyc < frz_at + 2);
         #1;
         if (!rdy) begin
            check("frz_burst_valid", resp_valid, 0);
         end else begin
            check("burst_valid", resp_valid, 1);
            check("beat_data", resp_data, base_val + 32'((start + beats) % 8));
            check("beat_last", resp_last, 32'(beats == 7));
            if (resp_ready) beats++;
         end
         tick();
         cyc++;
      end
      rdy = 1'b1;
      check("beat_count", beats, 8);
      #1;
      check("req_ready_after_line", req_ready, 1);
      check("resp_valid_after_line", resp_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      load_we = 1'b0; load_addr = '0; load_data = '0;
      rdy0 = 1'b1; req_valid0 = 1'b0; req_addr0 = '0; resp_ready0 = 1'b0;
      load_we0 = 1'b0; load_addr0 = '0; load_data0 = '0;

      @(negedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_last", resp_last, 0);

      for (int i = 0; i < 16; i++) begin
         load_we = 1'b1; load_addr = 12'(i); load_data = 32'h1000 + 32'(i);
         load_we0 = 1'b1; load_addr0 = 4'(i); load_data0 = 32'h2000 + 32'(i);
         tick();
      end
      load_we = 1'b0; load_we0 = 1'b0;
      rst_n = 1'b1;
      tick();

      // basic line fill
      do_req(32'h20);
      wait_first(4, 0, 0);
      collect(32'h1008, 0, 1'b0, -1);

      // backpressure 1,0,0,1
      do_req(32'h20);
      wait_first(4, 0, 0);
      collect(32'h1008, 0, 1'b1, -1);

      // rdy freeze: 3 cycles in WAIT, 2 mid-burst
      do_req(32'h20);
      wait_first(7, 1, 3);
      collect(32'h1008, 0, 1'b0, 3);

      // mid-line request offset (critical word first when enabled)
      do_req(32'h14);
      wait_first(4, 0, 0);
      collect(32'h1000, START_14, 1'b0, -1);

      // latency 0 with address wrap on the small copy
      req_valid0 = 1'b1; req_addr0 = 32'h44;
      #1;
      check("t3_req_ready", req_ready0, 1);
      tick();
      req_valid0 = 1'b0;
      #1;
      check("t3_valid_next_cycle", resp_valid0, 1);
      for (int b = 0; b < 8; b++) begin
         resp_ready0 = 1'b1;
         #1;
         check("t3_beat_data", resp_data0, 32'h2000 + 32'((START_44 + b) % 8));
         check("t3_beat_last", resp_last0, 32'(b == 7));
         tick();
      end
      #1;
      check("t3_valid_done", resp_valid0, 0);
      check("t3_ready_done", req_ready0, 1);

      // load collision while stalled, then reset mid-burst
      do_req(32'h00);
      wait_first(4, 0, 0);
      resp_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         #1;
         check("t5_beat_data", resp_data, 32'h1000 + 32'(b));
         tick();
      end
      resp_ready = 1'b0;
      #1;
      check("t5_old_before_write", resp_data, 32'h1002);
      load_we = 1'b1; load_addr = 12'd2; load_data = 32'hDEAD;
      #1;
      check("t5_old_write_cycle", resp_data, 32'h1002);
      tick();
      load_we = 1'b0;
      #1;
      check("t5_new_after_write", resp_data, 32'hDEAD);
      resp_ready = 1'b1;
      tick();
      #1;
      check("t5_beat3_data", resp_data, 32'h1003);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", resp_valid, 0);
      check("t5_rst_last", resp_last, 0);
      check("t5_rst_ready", req_ready, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("t5_ready_after_rst", req_ready, 1);
      do_req(32'h20);
      wait_first(4, 0, 0);
      collect(32'h1008, 0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
